// File: rtl/quiz_round_controller.sv
// -----------------------------------------------------------------------------
// quiz_round_controller
//   Sequences one quiz round. It arms the buzzers, picks the first eligible
//   player to press, times the answer window and turns the host verdict into a
//   one-cycle score strobe for the downstream score keeper. It also drives the
//   winner/countdown display and the buzzer.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start             host start/next key, 1-cycle pulse
//   host_ok, host_ng  host verdict keys, 1-cycle pulses
//   abort             host abort key, 1-cycle pulse, beats every other input
//   btn[3:0]          debounced player buttons (level), btn[i] = player i+1
//   winner_id[3:0]    0 = none, 1..4 = answering player
//   score_up          1-cycle strobe: add 1 to winner_id
//   score_down        1-cycle strobe: subtract 1 from winner_id
//   countdown[3:0]    remaining answer ticks, 0 outside ANSWER
//   foul[3:0]         per-player false-start flags
//   buzzer            buzzer drive
//   state[1:0]        0 IDLE, 1 ARMED, 2 ANSWER, 3 DONE
//
// Handshake: score_up/score_down are fire-and-forget strobes qualified by
// winner_id in the same cycle. There is no ready; the score keeper must take
// every strobe. At most one strobe is issued per round, never both at once.
// -----------------------------------------------------------------------------
module quiz_round_controller #(
   parameter int TICK_DIV    = 50_000_000,
   parameter int ANSWER_SECS = 10,
   parameter int BUZZ_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       host_ok,
   input  logic       host_ng,
   input  logic       abort,
   input  logic [3:0] btn,
   output logic [3:0] winner_id,
   output logic       score_up,
   output logic       score_down,
   output logic [3:0] countdown,
   output logic [3:0] foul,
   output logic       buzzer,
   output logic [1:0] state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BUZZ_LOAD  = BW'(BUZZ_CYCLES - 1);
   localparam logic [3:0]    SECS       = 4'(ANSWER_SECS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ANSWER = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        st;
   logic [3:0]    btn_q;
   logic [3:0]    press;
   logic [3:0]    eligible;
   logic [3:0]    pick;
   logic [PW-1:0] presc;
   logic [BW-1:0] buzz_cnt;
   logic          one_key;
   logic          tick;
   logic          expire;

   assign state = st;

   // Only rising edges count, so a button held through a state change is not
   // a new press.
   assign press    = btn & ~btn_q;
   assign eligible = press & ~foul;

   // Lowest-indexed eligible press wins a tie.
   always_comb begin
      pick = 4'd0;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[i]) pick = 4'(i + 1);
      end
   end

   // Both verdict keys together are treated as a fumble and ignored.
   assign one_key = host_ok ^ host_ng;
   assign tick    = (presc == PRESC_LAST);
   // Expiry is the tick that takes the countdown from 1 to 0.
   assign expire  = tick && (countdown == 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= S_IDLE;
         btn_q      <= 4'd0;
         winner_id  <= 4'd0;
         countdown  <= 4'd0;
         foul       <= 4'd0;
         score_up   <= 1'b0;
         score_down <= 1'b0;
         buzzer     <= 1'b0;
         buzz_cnt   <= '0;
         presc      <= '0;
      end else begin
         btn_q      <= btn;
         score_up   <= 1'b0;
         score_down <= 1'b0;

         // Buzzer runs on its own once started; it survives DONE and the
         // return to IDLE, and only abort or reset cut it short.
         if (buzz_cnt != '0) buzz_cnt <= buzz_cnt - 1'b1;
         else                buzzer   <= 1'b0;

         if (abort) begin
            st        <= S_IDLE;
            winner_id <= 4'd0;
            countdown <= 4'd0;
            buzzer    <= 1'b0;
            buzz_cnt  <= '0;
            presc     <= '0;
         end else begin
            case (st)
               S_IDLE: begin
                  foul <= foul | press;
                  if (start) st <= S_ARMED;
               end
               S_ARMED: begin
                  // With every player fouled nothing is eligible and the
                  // round waits here for abort.
                  if (eligible != 4'd0) begin
                     st        <= S_ANSWER;
                     winner_id <= pick;
                     countdown <= SECS;
                     presc     <= '0;
                     buzzer    <= 1'b1;
                     buzz_cnt  <= BUZZ_LOAD;
                  end
               end
               S_ANSWER: begin
                  if (tick) begin
                     presc     <= '0;
                     countdown <= countdown - 4'd1;
                  end else begin
                     presc <= presc + 1'b1;
                  end
                  // A verdict in the expiry cycle wins over the timeout.
                  if (one_key) begin
                     st         <= S_DONE;
                     countdown  <= 4'd0;
                     score_up   <= host_ok;
                     score_down <= host_ng;
                  end else if (expire) begin
                     st         <= S_DONE;
                     score_down <= 1'b1;
                  end
               end
               S_DONE: begin
                  if (start) begin
                     st        <= S_IDLE;
                     winner_id <= 4'd0;
                     foul      <= 4'd0;
                  end
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_quiz_round_controller.sv
// -----------------------------------------------------------------------------
// tb_quiz_round_controller
//   Self-checking bench for quiz_round_controller. A round-level reference
//   model predicts the outputs after each clock edge; score strobes are pushed
//   into a scoreboard queue and popped by a separate monitor.
// -----------------------------------------------------------------------------
module tb_quiz_round_controller;

   localparam int TICK_DIV    = 4;
   localparam int ANSWER_SECS = 3;
   localparam int BUZZ_CYCLES = 5;
   localparam int WIN_LEN     = TICK_DIV * ANSWER_SECS;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       host_ok = 1'b0;
   logic       host_ng = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] btn = 4'd0;
   logic [3:0] winner_id;
   logic       score_up;
   logic       score_down;
   logic [3:0] countdown;
   logic [3:0] foul;
   logic       buzzer;
   logic [1:0] state;

   always #5 clk = ~clk;

   quiz_round_controller #(
      .TICK_DIV   (TICK_DIV),
      .ANSWER_SECS(ANSWER_SECS),
      .BUZZ_CYCLES(BUZZ_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .host_ok   (host_ok),
      .host_ng   (host_ng),
      .abort     (abort),
      .btn       (btn),
      .winner_id (winner_id),
      .score_up  (score_up),
      .score_down(score_down),
      .countdown (countdown),
      .foul      (foul),
      .buzzer    (buzzer),
      .state     (state)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [5:0] exp_q[$];   // {up, down, winner_id}
   logic [5:0] sb_exp;
   bit         mon_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Time-based view of a round: the countdown and buzzer are derived from
   // how many cycles have elapsed since the winning press.
   int         m_state, m_win, m_win_cyc, m_buzz_end, m_cyc;
   logic [3:0] m_foul, m_prev_btn;
   int         e_state, e_win, e_cd;
   logic [3:0] e_foul;
   bit         e_buzz;

   task automatic model_reset();
      m_state = 0; m_win = 0; m_win_cyc = 0; m_buzz_end = -1; m_cyc = 0;
      m_foul = 4'd0; m_prev_btn = 4'd0;
      e_state = 0; e_win = 0; e_cd = 0; e_foul = 4'd0; e_buzz = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic s, input logic ok, input logic ng,
                             input logic ab, input logic [3:0] b);
      logic [3:0] press;
      logic [3:0] elig;
      press      = b & ~m_prev_btn;
      m_prev_btn = b;
      if (ab) begin
         m_state = 0; m_win = 0; m_buzz_end = m_cyc;
      end else begin
         case (m_state)
            0: begin
               m_foul = m_foul | press;
               if (s) m_state = 1;
            end
            1: begin
               elig = press & ~m_foul;
               for (int i = 0; i < 4; i++) begin
                  if (elig[i] && m_state == 1) begin
                     m_win = i + 1; m_state = 2;
                     m_win_cyc = m_cyc; m_buzz_end = m_cyc + BUZZ_CYCLES;
                  end
               end
            end
            2: begin
               if (ok != ng) begin
                  exp_q.push_back({ok, ng, 4'(m_win)});
                  m_state = 3;
               end else if (m_cyc == m_win_cyc + WIN_LEN) begin
                  exp_q.push_back({1'b0, 1'b1, 4'(m_win)});
                  m_state = 3;
               end
            end
            default: begin
               if (s) begin m_state = 0; m_win = 0; m_foul = 4'd0; end
            end
         endcase
      end
      e_state = m_state;
      e_win   = m_win;
      e_foul  = m_foul;
      e_buzz  = (m_cyc + 1 <= m_buzz_end);
      e_cd    = (m_state == 2) ? ANSWER_SECS - (m_cyc - m_win_cyc) / TICK_DIV : 0;
      m_cyc++;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         check("state", int'(state), e_state);
         check("winner_id", int'(winner_id), e_win);
         check("countdown", int'(countdown), e_cd);
         check("foul", int'(foul), int'(e_foul));
         check("buzzer", int'(buzzer), int'(e_buzz));
         if (score_up || score_down || exp_q.size() != 0) begin
            sb_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'd0;
            check("score{up,down,id}", int'({score_up, score_down, winner_id}), int'(sb_exp));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; covers exactly one rising edge.
   task automatic drive(input logic s, input logic ok, input logic ng,
                        input logic ab, input logic [3:0] b);
      start = s; host_ok = ok; host_ng = ng; abort = ab; btn = b;
      model_step(s, ok, ng, ab, b);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, btn);
   endtask

   task automatic do_reset();
      start = 1'b0; host_ok = 1'b0; host_ng = 1'b0; abort = 1'b0; btn = 4'd0;
      #2 rst = 1'b1;
      #1;
      check("rst_state", int'(state), 0);
      check("rst_winner", int'(winner_id), 0);
      check("rst_countdown", int'(countdown), 0);
      check("rst_foul", int'(foul), 0);
      check("rst_buzzer", int'(buzzer), 0);
      check("rst_score", int'({score_up, score_down}), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [3:0] nb;
   int         r;

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("init_state", int'(state), 0);
      check("init_winner", int'(winner_id), 0);
      check("init_countdown", int'(countdown), 0);
      check("init_foul", int'(foul), 0);
      check("init_buzzer", int'(buzzer), 0);
      check("init_score", int'({score_up, score_down}), 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Basic round: player 2 wins, host says correct.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0010);
      idle(2);
      drive(0, 1, 0, 0, 4'b0010);
      drive(0, 0, 0, 0, 4'b0000);
      drive(1, 0, 0, 0, 4'b0000);

      // False start by player 1, then a tie with player 2 goes to player 2.
      drive(0, 0, 0, 0, 4'b0001);
      drive(0, 0, 0, 0, 4'b0000);
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0011);
      drive(0, 0, 1, 0, 4'b0000);
      drive(1, 0, 0, 0, 4'b0000);

      // Tie between players 3 and 4, then timeout.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b1100);
      idle(WIN_LEN + 2);
      drive(1, 0, 0, 0, 4'b0000);

      // Host verdict lands exactly in the expiry cycle.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0001);
      idle(WIN_LEN - 1);
      drive(0, 1, 0, 0, 4'b0001);
      drive(1, 0, 0, 0, 4'b0000);

      // Both verdict keys at once are ignored; abort keeps the foul flags.
      drive(0, 0, 0, 0, 4'b1000);
      drive(0, 0, 0, 0, 4'b0000);
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0100);
      drive(0, 1, 1, 0, 4'b0100);
      idle(1);
      drive(0, 0, 0, 1, 4'b0000);

      // Abort beats a press in the same cycle.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 1, 4'b0001);
      idle(2);

      // Reset in the middle of an answer.
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b0010);
      idle(3);
      do_reset();
      idle(5);

      // Everyone fouled: the round can only be aborted.
      drive(0, 0, 0, 0, 4'b1111);
      drive(1, 0, 0, 0, 4'b0000);
      drive(0, 0, 0, 0, 4'b1111);
      idle(3);
      drive(0, 0, 0, 1, 4'b0000);
      do_reset();

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            nb = btn;
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(0, 9) == 0) nb[i] = ~nb[i];
            end
            r = $urandom_range(0, 31);
            drive(r < 4, r == 4 || r == 6, r == 5 || r == 6,
                  $urandom_range(0, 63) == 0, nb);
         end
      end

      drive(0, 0, 0, 1, 4'b0000);
      idle(3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
